// File: rtl/fc1_comma_align.sv
// ---------------------------------------------------------------------------
// fc1_comma_align
// Receive-side FC-1 word aligner. Finds the K28.5 comma bit position in the
// non-aligned 40-bit SERDES stream, holds that offset through a
// hunt/verify/lock state machine, and re-slices the stream so that character
// 0 of every output word starts on a comma boundary.
//
// Ports
//   rx_clk         in   receive line clock, single clock domain
//   reset_rx_clk   in   asynchronous active-high reset
//   rx_phy_data    in   40b non-aligned PHY word, bit 0 earliest received
//   rx_phy_los     in   loss of signal, forces HUNT and clears offset
//   ena_det        in   permits acquisition of a new alignment
//   rx_align_data  out  40b comma-aligned word, [9:0] = character 0
//   comma_det      out  alignment offset held (VERIFY or LOCKED)
//   sync_acqurd    out  LOCKED
//   frm_pat        out  rx_align_data[6:0] is a comma
//   align_offset   out  current bit offset 0..39
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_HUNT   | no offset held; waiting for any comma with ena_det high
// ST_VERIFY | offset latched; counting aligned commas up to LOCK_CNT
// ST_LOCKED | sync declared; misaligned commas count toward LOSS_CNT
// ---------------------------------------------------------------------------
module fc1_comma_align #(
   parameter int LOCK_CNT = 3,
   parameter int LOSS_CNT = 4
) (
   input  logic        rx_clk,
   input  logic        reset_rx_clk,
   input  logic [39:0] rx_phy_data,
   input  logic        rx_phy_los,
   input  logic        ena_det,
   output logic [39:0] rx_align_data,
   output logic        comma_det,
   output logic        sync_acqurd,
   output logic        frm_pat,
   output logic [5:0]  align_offset
);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [2:0] LOCK_VAL = 3'(LOCK_CNT);
   localparam logic [2:0] LOSS_VAL = 3'(LOSS_CNT);

   state_t      r_state;
   logic [39:0] r_prev;
   logic [2:0]  r_vcnt;
   logic [2:0]  r_ecnt;
   logic [5:0]  r_off;
   logic [39:0] r_data;
   logic        r_comma_det;
   logic        r_sync;
   logic        r_frm;

   logic [79:0] w_win;
   logic [39:0] w_hit;
   logic        w_any;
   logic        w_hit_held;
   logic [5:0]  w_first;
   logic [6:0]  w_sel_idx;

   state_t      w_state_nxt;
   logic [2:0]  w_vcnt_nxt;
   logic [2:0]  w_ecnt_nxt;
   logic [5:0]  w_off_nxt;
   logic [2:0]  w_vcnt_inc;
   logic [2:0]  w_ecnt_inc;

   assign w_win = {rx_phy_data, r_prev};

   // Comma search at every bit position of the two-word window. Offsets up to
   // 39 reach win[45], so a comma straddling the word boundary is still found.
   genvar gk;
   generate
      for (gk = 0; gk < 40; gk++) begin : g_hit
         assign w_hit[gk] = (w_win[gk +: 7] == 7'b1111100) ||
                            (w_win[gk +: 7] == 7'b0000011);
      end
   endgenerate

   assign w_any      = |w_hit;
   assign w_hit_held = w_hit[r_off];

   // Lowest hitting offset wins when several commas appear in one window.
   always_comb begin
      w_first = '0;
      for (int k = 39; k >= 0; k--) begin
         if (w_hit[k]) begin
            w_first = 6'(k);
         end
      end
   end

   assign w_vcnt_inc = r_vcnt + 3'd1;
   assign w_ecnt_inc = r_ecnt + 3'd1;

   always_comb begin
      w_state_nxt = r_state;
      w_vcnt_nxt  = r_vcnt;
      w_ecnt_nxt  = r_ecnt;
      w_off_nxt   = r_off;
      if (rx_phy_los) begin
         w_state_nxt = ST_HUNT;
         w_vcnt_nxt  = 3'd0;
         w_ecnt_nxt  = 3'd0;
         w_off_nxt   = 6'd0;
      end else begin
         case (r_state)
            ST_HUNT: begin
               if (ena_det && w_any) begin
                  w_off_nxt   = w_first;
                  w_vcnt_nxt  = 3'd1;
                  w_state_nxt = ST_VERIFY;
               end
            end
            ST_VERIFY: begin
               if (w_hit_held) begin
                  w_vcnt_nxt = w_vcnt_inc;
                  if (w_vcnt_inc == LOCK_VAL) begin
                     w_state_nxt = ST_LOCKED;
                     w_ecnt_nxt  = 3'd0;
                  end
               end else if (w_any && ena_det) begin
                  w_off_nxt  = w_first;
                  w_vcnt_nxt = 3'd1;
               end
            end
            ST_LOCKED: begin
               if (w_hit_held) begin
                  if (r_ecnt != 3'd0) begin
                     w_ecnt_nxt = r_ecnt - 3'd1;
                  end
               end else if (w_any) begin
                  // Offset is deliberately kept on loss; only a new
                  // acquisition in HUNT replaces it.
                  if (w_ecnt_inc == LOSS_VAL) begin
                     w_state_nxt = ST_HUNT;
                     w_vcnt_nxt  = 3'd0;
                     w_ecnt_nxt  = 3'd0;
                  end else begin
                     w_ecnt_nxt = w_ecnt_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_HUNT;
               w_vcnt_nxt  = 3'd0;
               w_ecnt_nxt  = 3'd0;
               w_off_nxt   = 6'd0;
            end
         endcase
      end
   end

   // Data and flag use the offset being written back this cycle, so the first
   // aligned word already carries comma_det.
   assign w_sel_idx = {1'b0, w_off_nxt};

   always_ff @(posedge rx_clk or posedge reset_rx_clk) begin
      if (reset_rx_clk) begin
         r_state     <= ST_HUNT;
         r_prev      <= '0;
         r_vcnt      <= '0;
         r_ecnt      <= '0;
         r_off       <= '0;
         r_data      <= '0;
         r_comma_det <= 1'b0;
         r_sync      <= 1'b0;
         r_frm       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_prev      <= rx_phy_data;
         r_vcnt      <= w_vcnt_nxt;
         r_ecnt      <= w_ecnt_nxt;
         r_off       <= w_off_nxt;
         r_data      <= w_win[w_sel_idx +: 40];
         r_comma_det <= (w_state_nxt != ST_HUNT);
         r_sync      <= (w_state_nxt == ST_LOCKED);
         r_frm       <= w_hit[w_off_nxt];
      end
   end

   assign rx_align_data = r_data;
   assign comma_det     = r_comma_det;
   assign sync_acqurd   = r_sync;
   assign frm_pat       = r_frm;
   assign align_offset  = r_off;

endmodule

// File: doc/fc1_comma_align.md
# fc1_comma_align

Receive-side FC-1 word aligner that sits directly upstream of the FC MAC receive path. It takes the non-aligned 40-bit SERDES word stream (four 10b characters), finds the K28.5 comma bit position, and re-slices the stream so that character 0 of every output word starts on a comma boundary. It runs a hunt/verify/lock synchronization state machine and drives `rx_align_data`, `comma_det`, `sync_acqurd` and `frm_pat` toward the MAC.

## Interface
Parameters:
- `LOCK_CNT`, 3: consecutive aligned commas needed to declare sync; range 2..7.
- `LOSS_CNT`, 4: error-counter value that drops sync; range 2..7.

Ports:
- `rx_clk`  in  1  receive line clock; all logic in this domain.
- `reset_rx_clk`  in  1  asynchronous, active-high reset.
- `rx_phy_data`  in  40  non-aligned PHY data.
  - Bit 0 is the earliest received bit.
  - Each 10b character is ordered abcdeifghj from low bit to high bit.
- `rx_phy_los`  in  1  loss of signal (level).
- `ena_det`  in  1  permits acquisition of a new alignment.
- `rx_align_data`  out  40  comma-aligned data; bits [9:0] hold character 0.
- `comma_det`  out  1  high while an alignment offset is held (VERIFY or LOCKED).
- `sync_acqurd`  out  1  high in LOCKED.
- `frm_pat`  out  1  one-cycle flag: `rx_align_data[6:0]` is a comma.
- `align_offset`  out  6  current bit offset, 0..39.

## Operation
- **Prev register.** `prev_q` (40 bits) registers `rx_phy_data` every cycle.
- **Window.** `win[79:0]` = {`rx_phy_data`, `prev_q`}.
  - The candidate word at offset k is `win[k+39:k]`, for k = 0..39.
- **Comma match.** Offset k matches when `win[k+6:k]` equals either 7'b1111100 or 7'b0000011.
  - These are bit vectors, MSB first; abcdeif = 0011111 or 1100000.
  - All 40 offsets are checked in parallel, giving `hit[39:0]`.
- **State machine.** States HUNT, VERIFY, LOCKED. Counters: `vcnt` (3 bits) and `ecnt` (3 bits).
- **Any state:** `rx_phy_los`=1 forces HUNT. It also clears `vcnt`, `ecnt` and `align_offset`. It has priority over all other events.
- **HUNT:**
  - If `ena_det`=1 and `hit`≠0: latch the lowest set k into `align_offset`, set `vcnt`=1, go to VERIFY.
  - Otherwise stay in HUNT with the offset unchanged.
- **VERIFY:**
  - `hit[align_offset]`=1: `vcnt`+1. When it reaches LOCK_CNT, go to LOCKED with `ecnt`=0.
  - Else, if `hit`≠0 and `ena_det`=1: re-latch the lowest set k and set `vcnt`=1.
  - A window with no hit is neutral.
- **LOCKED:**
  - `hit[align_offset]`=1: `ecnt` decrements, floor 0.
  - Else, if `hit`≠0 (misaligned comma): `ecnt` increments. When it reaches LOSS_CNT, go to HUNT with `vcnt`=0 and `ecnt`=0. The offset is retained until the next HUNT acquisition.
  - A window with no hit is neutral.
- **Multiple hits.** If several offsets hit in one window, a hit at the held offset always counts as aligned; the other hits are ignored.
- **Data output.** `rx_align_data` is registered from `win[k+39:k]`, using the offset value that is written back in that same cycle.
  - In HUNT the data follows the held offset, which is 0 after reset.
- **Flag output.** `frm_pat` is registered as (`win[k+6:k]` is a comma) with the same k.
- **Reset (`reset_rx_clk`=1):**
  - State = HUNT; `prev_q`, counters and offset = 0.
  - All outputs are 0: `rx_align_data`=0, `comma_det`=0, `sync_acqurd`=0, `frm_pat`=0, `align_offset`=0.
  - A reset in the middle of VERIFY or LOCKED drops sync immediately and asynchronously.

## Timing
- **Data latency.** A comma whose first bit is in `rx_phy_data` at cycle t sits in `prev_q` during cycle t+1. It appears aligned in `rx_align_data[6:0]`, with `frm_pat`=1, in cycle t+2: 2 cycles total.
- **Status latency.** `comma_det`, `sync_acqurd` and `align_offset` change at the same edge as the `rx_align_data` word that caused the change.
  - The first aligned word is therefore output with `comma_det`=1 already set.
- **Lock time.** LOCKED is reached on the edge that registers the LOCK_CNT-th aligned comma.
- **LOS drop.** `rx_phy_los` sampled high at edge n gives `sync_acqurd`=0 and `comma_det`=0 after edge n.
- **Boundary offsets.** Offset 0 outputs `prev_q` verbatim. Offset 39 takes `prev_q[39]` and `rx_phy_data[38:0]`.
- **Back-pressure.** None; a new output word is produced every cycle.

## Test plan
- **Basic lock.** Stream of idles: K28.5 RD- as char 0 every 4th word, bit-shifted by 13, `ena_det`=1 → `align_offset`=13. `comma_det` rises 2 cycles after the first comma. `sync_acqurd` rises with the 3rd comma word. `rx_align_data[9:0]`=10'b0101111100 on comma words.
- **Edge offsets.** Repeat with shifts 0 and 39 → lock at offsets 0 and 39; aligned data is bit-exact against the unshifted source.
- **Misalignment loss.** After lock at 13, inject 4 commas at offset 20 with no aligned commas between them → `sync_acqurd` falls after the 4th. Then hunt reacquires at 20 when `ena_det`=1. Also: alternating aligned/misaligned commas → lock is held.
- **ena_det gating.** `ena_det`=0 in HUNT with commas present → stays HUNT, `comma_det`=0. Raising `ena_det` → acquires on the next comma.
- **LOS and reset.** `rx_phy_los` pulsed for 1 cycle while LOCKED → all status drops next edge and `align_offset`=0, then relock after 3 commas. `reset_rx_clk` asserted asynchronously mid-VERIFY → all outputs 0 immediately.
- **Simultaneous hits.** Window with hits at offsets 5 and 25 in HUNT → offset 5 is chosen.
